// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - control bundle between the Mini SRC sequencer and its datapath
interface control_unit_if;
    logic [31:0] ir;
    logic        con_ff;
    logic        stop;
    logic        PCout, IncPC, ZLOout, ZLOin, Cout, MDRout, RAMenable;
    logic        MARin, PCin, MDRin, IRin, Yin;
    logic        Gra, Grb, Grc, Rin, Rout, BAout;
    logic        read, write, conin;
    logic        ZMuxEnable, ZSelect, ZMuxOut;
    logic        OutPortenable, PortInout, R15in;
    logic [4:0]  aluControl;
    logic        dpClear;
    logic        run;

    modport master (
        input  ir, con_ff, stop,
        output PCout, IncPC, ZLOout, ZLOin, Cout, MDRout, RAMenable,
        output MARin, PCin, MDRin, IRin, Yin,
        output Gra, Grb, Grc, Rin, Rout, BAout,
        output read, write, conin,
        output ZMuxEnable, ZSelect, ZMuxOut,
        output OutPortenable, PortInout, R15in,
        output aluControl, dpClear, run
    );

    modport slave (
        output ir, con_ff, stop,
        input  PCout, IncPC, ZLOout, ZLOin, Cout, MDRout, RAMenable,
        input  MARin, PCin, MDRin, IRin, Yin,
        input  Gra, Grb, Grc, Rin, Rout, BAout,
        input  read, write, conin,
        input  ZMuxEnable, ZSelect, ZMuxOut,
        input  OutPortenable, PortInout, R15in,
        input  aluControl, dpClear, run
    );
endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired T-state control sequencer for the Mini SRC datapath
module control_unit (
    input  logic              clock,
    input  logic              clear,
    control_unit_if.master    bus
);
    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_STOPPED, S_HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t     r_state;
    state_t     w_last;
    state_t     w_enter0;
    logic [4:0] r_opcode;
    logic       w_mem, w_alu, w_imm;

    always_comb begin
        w_mem = (r_opcode == OP_LD) || (r_opcode == OP_LDI) || (r_opcode == OP_ST);
        w_alu = (r_opcode == OP_ADD) || (r_opcode == OP_SUB) ||
                (r_opcode == OP_AND) || (r_opcode == OP_OR);
        w_imm = (r_opcode == OP_ADDI) || (r_opcode == OP_ANDI) || (r_opcode == OP_ORI);
        case (r_opcode)
            OP_LD, OP_ST: w_last = S_T7;
            OP_BR:        w_last = S_T6;
            OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI:
                          w_last = S_T5;
            default:      w_last = S_T3;
        endcase
        w_enter0 = bus.stop ? S_STOPPED : S_T0;
    end

    // Falling-edge state so controls are settled across the datapath's rising-edge capture.
    always_ff @(negedge clock or negedge clear) begin
        if (!clear) begin
            r_state  <= S_RESET;
            r_opcode <= 5'b00000;
        end else begin
            case (r_state)
                S_RESET: r_state <= S_T0;
                S_T0:    r_state <= S_T1;
                S_T1:    r_state <= S_T2;
                S_T2: begin
                    r_state  <= S_T3;
                    r_opcode <= bus.ir[31:27];
                end
                S_T3: begin
                    if (r_opcode == OP_HALT)  r_state <= S_HALT;
                    else if (w_last == S_T3)  r_state <= w_enter0;
                    else                      r_state <= S_T4;
                end
                S_T4:    r_state <= S_T5;
                S_T5:    r_state <= (w_last == S_T5) ? w_enter0 : S_T6;
                S_T6:    r_state <= (w_last == S_T6) ? w_enter0 : S_T7;
                S_T7:    r_state <= w_enter0;
                S_STOPPED: if (!bus.stop) r_state <= S_T0;
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_RESET;
            endcase
        end
    end

    always_comb begin
        bus.PCout = 1'b0;  bus.IncPC = 1'b0;  bus.ZLOout = 1'b0;  bus.ZLOin = 1'b0;
        bus.Cout = 1'b0;   bus.MDRout = 1'b0; bus.RAMenable = 1'b0;
        bus.MARin = 1'b0;  bus.PCin = 1'b0;   bus.MDRin = 1'b0;   bus.IRin = 1'b0;
        bus.Yin = 1'b0;    bus.Gra = 1'b0;    bus.Grb = 1'b0;     bus.Grc = 1'b0;
        bus.Rin = 1'b0;    bus.Rout = 1'b0;   bus.BAout = 1'b0;
        bus.read = 1'b0;   bus.write = 1'b0;  bus.conin = 1'b0;
        bus.ZMuxEnable = 1'b0; bus.ZSelect = 1'b0; bus.ZMuxOut = 1'b0;
        bus.OutPortenable = 1'b0; bus.PortInout = 1'b0; bus.R15in = 1'b0;
        bus.aluControl = 5'b00000;
        bus.dpClear = ~clear;
        bus.run = (r_state != S_RESET) && (r_state != S_STOPPED) && (r_state != S_HALT);
        case (r_state)
            S_T0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; end
            S_T1: begin bus.read = 1'b1; bus.RAMenable = 1'b1; bus.MDRin = 1'b1; end
            S_T2: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
            S_T3: begin
                if (w_mem) begin
                    bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
                end else if (w_alu || w_imm) begin
                    bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
                end else if (r_opcode == OP_BR) begin
                    bus.Gra = 1'b1; bus.Rout = 1'b1; bus.conin = 1'b1;
                end else if (r_opcode == OP_JR) begin
                    bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1;
                end else if (r_opcode == OP_IN) begin
                    bus.PortInout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                end else if (r_opcode == OP_OUT) begin
                    bus.Gra = 1'b1; bus.Rout = 1'b1; bus.OutPortenable = 1'b1;
                end
            end
            S_T4: begin
                if (w_alu) begin
                    bus.Grc = 1'b1; bus.Rout = 1'b1; bus.ZLOin = 1'b1;
                    bus.aluControl = r_opcode;
                end else if (w_mem || w_imm) begin
                    bus.Cout = 1'b1; bus.ZLOin = 1'b1;
                    case (r_opcode)
                        OP_ANDI: bus.aluControl = OP_AND;
                        OP_ORI:  bus.aluControl = OP_OR;
                        default: bus.aluControl = OP_ADD;
                    endcase
                end else if (r_opcode == OP_BR) begin
                    bus.PCout = 1'b1; bus.Yin = 1'b1;
                end
            end
            S_T5: begin
                if (r_opcode == OP_LD || r_opcode == OP_ST) begin
                    bus.ZLOout = 1'b1; bus.MARin = 1'b1;
                end else if (r_opcode == OP_BR) begin
                    bus.Cout = 1'b1; bus.ZLOin = 1'b1; bus.aluControl = OP_ADD;
                end else begin
                    bus.ZLOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                end
            end
            S_T6: begin
                if (r_opcode == OP_LD) begin
                    bus.read = 1'b1; bus.RAMenable = 1'b1; bus.MDRin = 1'b1;
                end else if (r_opcode == OP_ST) begin
                    bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1;
                end else if (bus.con_ff) begin
                    bus.ZLOout = 1'b1; bus.PCin = 1'b1;
                end
            end
            S_T7: begin
                if (r_opcode == OP_LD) begin
                    bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                end else begin
                    bus.write = 1'b1; bus.RAMenable = 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed table-driven bench for control_unit
module tb_control_unit;
    logic clock;
    logic clear;
    control_unit_if bus();

    control_unit dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.master)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    localparam logic [26:0] M_PCOUT  = 27'h1 << 26;
    localparam logic [26:0] M_INCPC  = 27'h1 << 25;
    localparam logic [26:0] M_ZLOOUT = 27'h1 << 24;
    localparam logic [26:0] M_ZLOIN  = 27'h1 << 23;
    localparam logic [26:0] M_COUT   = 27'h1 << 22;
    localparam logic [26:0] M_MDROUT = 27'h1 << 21;
    localparam logic [26:0] M_RAMEN  = 27'h1 << 20;
    localparam logic [26:0] M_MARIN  = 27'h1 << 19;
    localparam logic [26:0] M_PCIN   = 27'h1 << 18;
    localparam logic [26:0] M_MDRIN  = 27'h1 << 17;
    localparam logic [26:0] M_IRIN   = 27'h1 << 16;
    localparam logic [26:0] M_YIN    = 27'h1 << 15;
    localparam logic [26:0] M_GRA    = 27'h1 << 14;
    localparam logic [26:0] M_GRB    = 27'h1 << 13;
    localparam logic [26:0] M_GRC    = 27'h1 << 12;
    localparam logic [26:0] M_RIN    = 27'h1 << 11;
    localparam logic [26:0] M_ROUT   = 27'h1 << 10;
    localparam logic [26:0] M_BAOUT  = 27'h1 << 9;
    localparam logic [26:0] M_READ   = 27'h1 << 8;
    localparam logic [26:0] M_WRITE  = 27'h1 << 7;
    localparam logic [26:0] M_CONIN  = 27'h1 << 6;
    localparam logic [26:0] M_OUTP   = 27'h1 << 2;
    localparam logic [26:0] M_PORTIN = 27'h1 << 1;
    localparam logic [26:0] M_NONE   = 27'h0;

    localparam logic [26:0] F0 = M_PCOUT | M_MARIN | M_INCPC;
    localparam logic [26:0] F1 = M_READ | M_RAMEN | M_MDRIN;
    localparam logic [26:0] F2 = M_MDROUT | M_IRIN;

    localparam logic [31:0] IR_LDI  = 32'h09800005;
    localparam logic [31:0] IR_ADD  = 32'h18918000;
    localparam logic [31:0] IR_SUB  = 32'h20918000;
    localparam logic [31:0] IR_ANDI = 32'h68000000;
    localparam logic [31:0] IR_BR   = 32'h98000000;
    localparam logic [31:0] IR_ST   = 32'h10000000;
    localparam logic [31:0] IR_LD   = 32'h00000000;
    localparam logic [31:0] IR_JR   = 32'hA0000000;
    localparam logic [31:0] IR_IN   = 32'hB0000000;
    localparam logic [31:0] IR_OUT  = 32'hB8000000;
    localparam logic [31:0] IR_NOP  = 32'hD0000000;
    localparam logic [31:0] IR_UNK  = 32'hF8000000;
    localparam logic [31:0] IR_HALT = 32'hD8000000;

    typedef struct {
        logic [31:0] ir;
        logic        con;
        logic        stp;
        logic [26:0] ctl;
        logic [4:0]  alu;
        logic        run;
        string       name;
    } vec_t;

    vec_t vt[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [26:0] act_ctl;
    assign act_ctl = {bus.PCout, bus.IncPC, bus.ZLOout, bus.ZLOin, bus.Cout, bus.MDRout,
                      bus.RAMenable, bus.MARin, bus.PCin, bus.MDRin, bus.IRin, bus.Yin,
                      bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout,
                      bus.read, bus.write, bus.conin, bus.ZMuxEnable, bus.ZSelect,
                      bus.ZMuxOut, bus.OutPortenable, bus.PortInout, bus.R15in};

    task automatic check(input string nm, input logic [26:0] ctl, input logic [4:0] alu,
                         input logic run, input logic dpclr);
        logic [33:0] act, exp;
        act = {act_ctl, bus.aluControl, bus.run, bus.dpClear};
        exp = {ctl, alu, run, dpclr};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got ctl=%h alu=%b run=%b dpClear=%b, want ctl=%h alu=%b run=%b dpClear=%b",
                     nm, act_ctl, bus.aluControl, bus.run, bus.dpClear, ctl, alu, run, dpclr);
        end
    endtask

    task automatic step(input logic [31:0] ir, input logic con, input logic stp,
                        input logic [26:0] ctl, input logic [4:0] alu, input logic run,
                        input string nm);
        @(posedge clock);
        #1;
        bus.ir = ir;
        bus.con_ff = con;
        bus.stop = stp;
        #1;
        check(nm, ctl, alu, run, 1'b0);
    endtask

    task automatic push(input logic [31:0] ir, input logic con, input logic [26:0] ctl,
                        input logic [4:0] alu, input string nm);
        vt.push_back('{ir: ir, con: con, stp: 1'b0, ctl: ctl, alu: alu, run: 1'b1, name: nm});
    endtask

    task automatic fetch(input logic [31:0] ir, input string nm);
        push(ir, 1'b0, F0, 5'd0, {nm, "_T0"});
        push(ir, 1'b0, F1, 5'd0, {nm, "_T1"});
        push(ir, 1'b0, F2, 5'd0, {nm, "_T2"});
    endtask

    task automatic pulse_clear(input string nm, input int cycles);
        @(posedge clock);
        #1;
        clear = 1'b0;
        #1;
        check({nm, "_0"}, M_NONE, 5'd0, 1'b0, 1'b1);
        for (int i = 1; i < cycles; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("%s_%0d", nm, i), M_NONE, 5'd0, 1'b0, 1'b1);
        end
        clear = 1'b1;
    endtask

    initial begin
        clear = 1'b0;
        bus.ir = 32'h0;
        bus.con_ff = 1'b0;
        bus.stop = 1'b0;

        fetch(IR_LDI, "ldi");
        push(IR_LDI, 1'b0, M_GRB | M_BAOUT | M_YIN, 5'd0, "ldi_T3");
        push(IR_LDI, 1'b0, M_COUT | M_ZLOIN, 5'b00011, "ldi_T4");
        push(IR_LDI, 1'b0, M_ZLOOUT | M_GRA | M_RIN, 5'd0, "ldi_T5");
        fetch(IR_ADD, "add");
        push(IR_ADD, 1'b0, M_GRB | M_ROUT | M_YIN, 5'd0, "add_T3");
        push(IR_ADD, 1'b0, M_GRC | M_ROUT | M_ZLOIN, 5'b00011, "add_T4");
        push(IR_ADD, 1'b0, M_ZLOOUT | M_GRA | M_RIN, 5'd0, "add_T5");
        fetch(IR_SUB, "sub");
        push(IR_SUB, 1'b0, M_GRB | M_ROUT | M_YIN, 5'd0, "sub_T3");
        push(IR_SUB, 1'b0, M_GRC | M_ROUT | M_ZLOIN, 5'b00100, "sub_T4");
        push(IR_SUB, 1'b0, M_ZLOOUT | M_GRA | M_RIN, 5'd0, "sub_T5");
        fetch(IR_ANDI, "andi");
        push(IR_ANDI, 1'b0, M_GRB | M_ROUT | M_YIN, 5'd0, "andi_T3");
        push(IR_ANDI, 1'b0, M_COUT | M_ZLOIN, 5'b01010, "andi_T4");
        push(IR_ANDI, 1'b0, M_ZLOOUT | M_GRA | M_RIN, 5'd0, "andi_T5");
        for (int t = 0; t < 2; t++) begin
            logic c;
            c = (t == 0);
            fetch(IR_BR, c ? "br1" : "br0");
            push(IR_BR, c, M_GRA | M_ROUT | M_CONIN, 5'd0, "br_T3");
            push(IR_BR, c, M_PCOUT | M_YIN, 5'd0, "br_T4");
            push(IR_BR, c, M_COUT | M_ZLOIN, 5'b00011, "br_T5");
            push(IR_BR, c, c ? (M_ZLOOUT | M_PCIN) : M_NONE, 5'd0, c ? "br1_T6" : "br0_T6");
        end
        fetch(IR_ST, "st");
        push(IR_ST, 1'b0, M_GRB | M_BAOUT | M_YIN, 5'd0, "st_T3");
        push(IR_ST, 1'b0, M_COUT | M_ZLOIN, 5'b00011, "st_T4");
        push(IR_ST, 1'b0, M_ZLOOUT | M_MARIN, 5'd0, "st_T5");
        push(IR_ST, 1'b0, M_GRA | M_ROUT | M_MDRIN, 5'd0, "st_T6");
        push(IR_ST, 1'b0, M_WRITE | M_RAMEN, 5'd0, "st_T7");
        fetch(IR_LD, "ld");
        push(IR_LD, 1'b0, M_GRB | M_BAOUT | M_YIN, 5'd0, "ld_T3");
        push(IR_LD, 1'b0, M_COUT | M_ZLOIN, 5'b00011, "ld_T4");
        push(IR_LD, 1'b0, M_ZLOOUT | M_MARIN, 5'd0, "ld_T5");
        push(IR_LD, 1'b0, M_READ | M_RAMEN | M_MDRIN, 5'd0, "ld_T6");
        push(IR_LD, 1'b0, M_MDROUT | M_GRA | M_RIN, 5'd0, "ld_T7");
        fetch(IR_JR, "jr");
        push(IR_JR, 1'b0, M_GRA | M_ROUT | M_PCIN, 5'd0, "jr_T3");
        fetch(IR_IN, "in");
        push(IR_IN, 1'b0, M_PORTIN | M_GRA | M_RIN, 5'd0, "in_T3");
        fetch(IR_OUT, "out");
        push(IR_OUT, 1'b0, M_GRA | M_ROUT | M_OUTP, 5'd0, "out_T3");
        fetch(IR_NOP, "nop");
        push(IR_NOP, 1'b0, M_NONE, 5'd0, "nop_T3");
        fetch(IR_UNK, "unk");
        push(IR_UNK, 1'b0, M_NONE, 5'd0, "unk_T3");

        @(posedge clock);
        #1;
        check("reset_state", M_NONE, 5'd0, 1'b0, 1'b1);
        clear = 1'b1;

        foreach (vt[i])
            step(vt[i].ir, vt[i].con, vt[i].stp, vt[i].ctl, vt[i].alu, vt[i].run, vt[i].name);

        // stop raised in the last state of add parks the sequencer until released
        step(IR_ADD, 1'b0, 1'b0, F0, 5'd0, 1'b1, "stp_T0");
        step(IR_ADD, 1'b0, 1'b0, F1, 5'd0, 1'b1, "stp_T1");
        step(IR_ADD, 1'b0, 1'b0, F2, 5'd0, 1'b1, "stp_T2");
        step(IR_ADD, 1'b0, 1'b0, M_GRB | M_ROUT | M_YIN, 5'd0, 1'b1, "stp_T3");
        step(IR_ADD, 1'b0, 1'b0, M_GRC | M_ROUT | M_ZLOIN, 5'b00011, 1'b1, "stp_T4");
        step(IR_ADD, 1'b0, 1'b1, M_ZLOOUT | M_GRA | M_RIN, 5'd0, 1'b1, "stp_T5");
        step(IR_ADD, 1'b0, 1'b1, M_NONE, 5'd0, 1'b0, "stopped_0");
        step(IR_ADD, 1'b0, 1'b1, M_NONE, 5'd0, 1'b0, "stopped_1");
        step(IR_ADD, 1'b0, 1'b0, M_NONE, 5'd0, 1'b0, "stopped_2");
        step(IR_ADD, 1'b0, 1'b0, F0, 5'd0, 1'b1, "resume_T0");

        step(IR_ADD, 1'b0, 1'b0, F1, 5'd0, 1'b1, "rst_T1");
        step(IR_ADD, 1'b0, 1'b0, F2, 5'd0, 1'b1, "rst_T2");
        step(IR_ADD, 1'b0, 1'b0, M_GRB | M_ROUT | M_YIN, 5'd0, 1'b1, "rst_T3");
        step(IR_ADD, 1'b0, 1'b0, M_GRC | M_ROUT | M_ZLOIN, 5'b00011, 1'b1, "rst_T4");
        pulse_clear("clear_midT4", 3);
        step(IR_HALT, 1'b0, 1'b0, F0, 5'd0, 1'b1, "after_clear_T0");

        step(IR_HALT, 1'b0, 1'b0, F1, 5'd0, 1'b1, "halt_T1");
        step(IR_HALT, 1'b0, 1'b0, F2, 5'd0, 1'b1, "halt_T2");
        step(IR_HALT, 1'b0, 1'b0, M_NONE, 5'd0, 1'b1, "halt_T3");
        for (int i = 0; i < 20; i++)
            step(IR_ADD, 1'b0, 1'b0, M_NONE, 5'd0, 1'b0, $sformatf("halt_hold_%0d", i));
        pulse_clear("clear_halt", 1);
        step(IR_ADD, 1'b0, 1'b0, F0, 5'd0, 1'b1, "post_halt_T0");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
